// File: rtl/pzhsbus_arbiter_pkg.sv
// Shared types and helpers for the pzhsbus round-robin arbiter.
//   pzhsbus_arbiter_state : arbiter FSM states (IDLE, GRANTED)
//   pzbcm_selector_type   : select encoding understood by pzbcm_selector
//   calc_count_width()    : width of the per-grant beat counter
package pzhsbus_arbiter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } pzhsbus_arbiter_state;

   typedef enum logic {
      PZBCM_SELECTOR_BINARY = 1'b0,
      PZBCM_SELECTOR_ONEHOT = 1'b1
   } pzbcm_selector_type;

   // Enough bits to hold 0..QUANTUM.
   function automatic int calc_count_width(int quantum);
      return $clog2(quantum + 1);
   endfunction

endpackage

// File: rtl/pzhsbus_if.sv
// pzhsbus handshake interface.
//   valid   : producer has a beat on payload
//   ready   : consumer accepts the beat this cycle
//   payload : beat data, held stable while valid && !ready
// master modport drives valid/payload; slave modport drives ready.
interface pzhsbus_if #(
   parameter int PAYLOAD_WIDTH = 8
);
   logic                     valid;
   logic                     ready;
   logic [PAYLOAD_WIDTH-1:0] payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pzbcm_selector.sv
// Generic N:1 selector.
//   i_select : one-hot (ONEHOT) or index in the low bits (BINARY)
//   i_data   : ENTRIES candidate words
//   o_data   : selected word, zero when nothing is selected
module pzbcm_selector
   import pzhsbus_arbiter_pkg::*;
#(
   parameter int                 WIDTH   = 8,
   parameter int                 ENTRIES = 2,
   parameter pzbcm_selector_type TYPE    = PZBCM_SELECTOR_ONEHOT
) (
   input  logic [ENTRIES-1:0]            i_select,
   input  logic [ENTRIES-1:0][WIDTH-1:0] i_data,
   output logic [WIDTH-1:0]              o_data
);

   always_comb begin
      o_data = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (TYPE == PZBCM_SELECTOR_ONEHOT) begin
            // AND-OR mux: no priority chain, relies on select being one-hot.
            if (i_select[i]) o_data = o_data | i_data[i];
         end else if (i_select == ENTRIES'(i)) begin
            o_data = i_data[i];
         end
      end
   end

endmodule

// File: rtl/pzhsbus_arbiter_rr.sv
// Combinational cyclic priority pick.
//   request : per-requester request vector
//   prio    : one-hot, highest-priority position
//   pick    : one-hot first request at or above prio (wrapping), zero if none
module pzhsbus_arbiter_rr #(
   parameter int REQUESTERS = 2
) (
   input  logic [REQUESTERS-1:0] request,
   input  logic [REQUESTERS-1:0] prio,
   output logic [REQUESTERS-1:0] pick
);

   logic [2*REQUESTERS-1:0] dbl;
   logic [2*REQUESTERS-1:0] masked;

   // Doubling the request vector turns the wrap-around search into a plain
   // "lowest set bit at or above prio" search, which a subtract finds in one go.
   assign dbl    = {request, request};
   assign masked = dbl & ~(dbl - {{REQUESTERS{1'b0}}, prio});
   assign pick   = masked[REQUESTERS-1:0] | masked[2*REQUESTERS-1:REQUESTERS];

endmodule

// File: rtl/pzhsbus_arbiter.sv
// Round-robin arbiter merging REQUESTERS pzhsbus producers onto one master port.
// A grant lasts up to QUANTUM handshakes or until the granted producer drops
// valid; one IDLE cycle separates consecutive grants.
//   i_clk, i_rst : clock, synchronous active-high reset
//   slave_if[]   : requester ports (arbiter drives ready)
//   master_if    : shared output port (arbiter drives valid/payload)
//   o_grant      : one-hot current grant, zero when idle
module pzhsbus_arbiter
   import pzhsbus_arbiter_pkg::*;
#(
   parameter int REQUESTERS    = 2,
   parameter int QUANTUM       = 1,
   parameter int PAYLOAD_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   pzhsbus_if.slave              slave_if [REQUESTERS],
   pzhsbus_if.master             master_if,
   output logic [REQUESTERS-1:0] o_grant
);

   localparam int COUNT_WIDTH = calc_count_width(QUANTUM);

   pzhsbus_arbiter_state    state_q, state_d;
   logic [REQUESTERS-1:0]   grant_q, grant_d;
   logic [REQUESTERS-1:0]   prio_q, prio_d;
   logic [COUNT_WIDTH-1:0]  count_q, count_d;

   logic [REQUESTERS-1:0]                    req_valid;
   logic [REQUESTERS-1:0]                    pick;
   logic [REQUESTERS-1:0][PAYLOAD_WIDTH:0]   sel_in;
   logic [PAYLOAD_WIDTH:0]                   sel_out;
   logic                                     sel_valid;
   logic                                     handshake;
   logic                                     last_beat;

   for (genvar i = 0; i < REQUESTERS; i++) begin : g_port
      assign req_valid[i]      = slave_if[i].valid;
      assign sel_in[i]         = {slave_if[i].valid, slave_if[i].payload};
      // grant is zero in IDLE, so no requester sees ready there.
      assign slave_if[i].ready = grant_q[i] & master_if.ready;
   end

   pzhsbus_arbiter_rr #(.REQUESTERS(REQUESTERS)) u_rr (
      .request (req_valid),
      .prio    (prio_q),
      .pick    (pick)
   );

   pzbcm_selector #(
      .WIDTH   (PAYLOAD_WIDTH + 1),
      .ENTRIES (REQUESTERS),
      .TYPE    (PZBCM_SELECTOR_ONEHOT)
   ) u_sel (
      .i_select (grant_q),
      .i_data   (sel_in),
      .o_data   (sel_out)
   );

   assign sel_valid         = sel_out[PAYLOAD_WIDTH];
   assign master_if.valid   = sel_valid;
   assign master_if.payload = sel_out[PAYLOAD_WIDTH-1:0];
   assign o_grant           = grant_q;

   assign handshake = sel_valid & master_if.ready;
   assign last_beat = (count_q == COUNT_WIDTH'(QUANTUM - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      prio_d  = prio_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               count_d = '0;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            // An idle (or illegally dropped) granted requester releases too;
            // either way release is a single event.
            if ((handshake && last_beat) || !sel_valid) begin
               prio_d  = {grant_q[REQUESTERS-2:0], grant_q[REQUESTERS-1]};
               grant_d = '0;
               count_d = '0;
               state_d = IDLE;
            end else if (handshake) begin
               count_d = count_q + COUNT_WIDTH'(1);
            end
         end
         default: begin
            grant_d = '0;
            count_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         prio_q  <= REQUESTERS'(1);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         prio_q  <= prio_d;
         count_q <= count_d;
      end
   end

endmodule
